// File: rtl/rv_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_pkg
// Brief    : Shared opcodes, FSM states, ALU codes and mux selects for rv_mc
// Revision : 1.0
// ============================================================================
package rv_mc_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_sel_t;
    typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_RS1, SRCA_ZERO} srca_sel_t;
    typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_FOUR} srcb_sel_t;
    typedef enum logic [1:0] {RES_ALUREG, RES_DATA, RES_ALURESULT} res_sel_t;
    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

    function automatic logic [31:0] imm_ext(input logic [31:0] instr, input imm_sel_t sel);
        logic [31:0] imm;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_ctrl
// Brief    : Controller wrapper: main FSM plus ALU-function decode and PC enable
// Revision : 1.0
// ============================================================================
module rv_mc_ctrl
    import rv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    output logic       we_ir_o,
    output logic       we_rf_o,
    output logic       we_mem_o,
    output logic       pc_we_o,
    output logic       adr_src_o,
    output srca_sel_t  srca_sel_o,
    output srcb_sel_t  srcb_sel_o,
    output res_sel_t   res_sel_o,
    output imm_sel_t   imm_sel_o,
    output logic [3:0] alu_control_o
);

    logic    pc_upd;
    logic    branch;
    alu_op_t alu_op;

    rv_mc_fsm fsm (
        .clk        (clk),
        .rst        (rst),
        .op_i       (op_i),
        .we_ir_o    (we_ir_o),
        .we_rf_o    (we_rf_o),
        .we_mem_o   (we_mem_o),
        .pc_upd_o   (pc_upd),
        .branch_o   (branch),
        .adr_src_o  (adr_src_o),
        .srca_sel_o (srca_sel_o),
        .srcb_sel_o (srcb_sel_o),
        .res_sel_o  (res_sel_o),
        .imm_sel_o  (imm_sel_o),
        .alu_op_o   (alu_op)
    );

    assign pc_we_o = pc_upd | (branch & zero_i);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Bit 30 is an immediate bit for addi, so only R-type may select sub.
                    3'b000: alu_control_o = (op_i == OP_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control_o = ALU_SLL;
                    3'b010: alu_control_o = ALU_SLT;
                    3'b011: alu_control_o = ALU_SLTU;
                    3'b100: alu_control_o = ALU_XOR;
                    3'b101: alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control_o = ALU_OR;
                    default: alu_control_o = ALU_AND;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_mc_fsm.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_fsm
// Brief    : Multicycle main controller: state sequencing and datapath selects
// Revision : 1.0
// ============================================================================
module rv_mc_fsm
    import rv_mc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic [6:0] op_i,
    output logic      we_ir_o,
    output logic      we_rf_o,
    output logic      we_mem_o,
    output logic      pc_upd_o,
    output logic      branch_o,
    output logic      adr_src_o,
    output srca_sel_t srca_sel_o,
    output srcb_sel_t srcb_sel_o,
    output res_sel_t  res_sel_o,
    output imm_sel_t  imm_sel_o,
    output alu_op_t   alu_op_o
);

    state_t state;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        we_ir_o    = 1'b0;
        we_rf_o    = 1'b0;
        we_mem_o   = 1'b0;
        pc_upd_o   = 1'b0;
        branch_o   = 1'b0;
        adr_src_o  = 1'b0;
        srca_sel_o = SRCA_PC;
        srcb_sel_o = SRCB_RS2;
        res_sel_o  = RES_ALUREG;
        imm_sel_o  = IMM_I;
        alu_op_o   = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                we_ir_o    = 1'b1;
                pc_upd_o   = 1'b1;
                srcb_sel_o = SRCB_FOUR;
                res_sel_o  = RES_ALURESULT;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // The jal target is precomputed here too, so JAL can reuse the ALU for the link value.
                srca_sel_o = SRCA_OLDPC;
                srcb_sel_o = SRCB_IMM;
                imm_sel_o  = (op_i == OP_JAL) ? IMM_J : IMM_B;
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE, OP_LUI:  state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                srca_sel_o = SRCA_RS1;
                srcb_sel_o = SRCB_IMM;
                imm_sel_o  = (op_i == OP_STORE) ? IMM_S : IMM_I;
                state_d    = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_o = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                res_sel_o = RES_DATA;
                we_rf_o   = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_o = 1'b1;
                we_mem_o  = 1'b1;
            end
            S_EXECR: begin
                srca_sel_o = SRCA_RS1;
                alu_op_o   = ALUOP_FUNCT;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                srcb_sel_o = SRCB_IMM;
                if (op_i == OP_LUI) begin
                    srca_sel_o = SRCA_ZERO;
                    imm_sel_o  = IMM_U;
                end else begin
                    srca_sel_o = SRCA_RS1;
                    alu_op_o   = ALUOP_FUNCT;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                we_rf_o = 1'b1;
            end
            S_BEQ: begin
                srca_sel_o = SRCA_RS1;
                alu_op_o   = ALUOP_SUB;
                branch_o   = 1'b1;
            end
            S_JAL: begin
                srca_sel_o = SRCA_OLDPC;
                srcb_sel_o = SRCB_FOUR;
                pc_upd_o   = 1'b1;
                state_d    = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_mc_mem.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_mem
// Brief    : Unified word memory, combinational read, synchronous write
// Revision : 1.0
// ============================================================================
module rv_mc_mem #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   RAM [0:MEM_WORDS-1];
    logic [AW-1:0] idx;
    logic          w_unused_addr;

    // Upper address bits are ignored, so higher addresses alias into the array.
    assign idx           = addr_i[AW+1:2];
    assign w_unused_addr = &{1'b0, addr_i[31:AW+2], addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (!rst && we_i) RAM[idx] <= wd_i;
    end

    assign rd_o = RAM[idx];

endmodule
`default_nettype wire

// File: rtl/rv_mc_regfile.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_regfile
// Brief    : 32x32 register file, two async read ports, one sync write port
// Revision : 1.0
// ============================================================================
module rv_mc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  a1_i,
    input  logic [4:0]  a2_i,
    input  logic [4:0]  a3_i,
    input  logic [31:0] wd3_i,
    input  logic        we3_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'b0;
        end else if (we3_i && (a3_i != 5'd0)) begin
            registers[a3_i] <= wd3_i;
        end
    end

    assign rd1_o = (a1_i == 5'd0) ? 32'b0 : registers[a1_i];
    assign rd2_o = (a2_i == 5'd0) ? 32'b0 : registers[a2_i];

endmodule
`default_nettype wire

// File: rtl/rv_mc.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc
// Brief    : Multicycle RV32I-subset core: shared memory, shared ALU, FSM control
// Revision : 1.0
// ============================================================================
module rv_mc
    import rv_mc_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h00000000
) (
    input  logic clk,
    input  logic rst
);

    logic [31:0] PC_reg, oldpc_q, instr_reg, a_q, b_q, data_q, alu_reg;
    logic [31:0] RD, adr, rd1, rd2, Result, ImmExt, SrcA, SrcB, AluResult;
    logic [3:0]  alu_control;
    logic        we_ir, we_rf, we_mem, pc_we, adr_src, zero;
    srca_sel_t   srca_sel;
    srcb_sel_t   srcb_sel;
    res_sel_t    res_sel;
    imm_sel_t    imm_sel;

    rv_mc_ctrl CTRL (
        .clk           (clk),
        .rst           (rst),
        .op_i          (instr_reg[6:0]),
        .funct3_i      (instr_reg[14:12]),
        .funct7b5_i    (instr_reg[30]),
        .zero_i        (zero),
        .we_ir_o       (we_ir),
        .we_rf_o       (we_rf),
        .we_mem_o      (we_mem),
        .pc_we_o       (pc_we),
        .adr_src_o     (adr_src),
        .srca_sel_o    (srca_sel),
        .srcb_sel_o    (srcb_sel),
        .res_sel_o     (res_sel),
        .imm_sel_o     (imm_sel),
        .alu_control_o (alu_control)
    );

    rv_mc_regfile REGFILE (
        .clk   (clk),
        .rst   (rst),
        .a1_i  (instr_reg[19:15]),
        .a2_i  (instr_reg[24:20]),
        .a3_i  (instr_reg[11:7]),
        .wd3_i (Result),
        .we3_i (we_rf),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    assign adr = adr_src ? alu_reg : PC_reg;

    rv_mc_mem #(.MEM_WORDS(MEM_WORDS)) MEM (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_mem),
        .addr_i (adr),
        .wd_i   (b_q),
        .rd_o   (RD)
    );

    assign ImmExt = imm_ext(instr_reg, imm_sel);

    always_comb begin
        case (srca_sel)
            SRCA_PC:    SrcA = PC_reg;
            SRCA_OLDPC: SrcA = oldpc_q;
            SRCA_RS1:   SrcA = a_q;
            default:    SrcA = 32'b0;
        endcase
        case (srcb_sel)
            SRCB_RS2:  SrcB = b_q;
            SRCB_IMM:  SrcB = ImmExt;
            SRCB_FOUR: SrcB = 32'd4;
            default:   SrcB = 32'b0;
        endcase
    end

    always_comb begin
        case (alu_control)
            ALU_ADD:  AluResult = SrcA + SrcB;
            ALU_SUB:  AluResult = SrcA - SrcB;
            ALU_AND:  AluResult = SrcA & SrcB;
            ALU_OR:   AluResult = SrcA | SrcB;
            ALU_XOR:  AluResult = SrcA ^ SrcB;
            ALU_SLT:  AluResult = {31'b0, $signed(SrcA) < $signed(SrcB)};
            ALU_SLTU: AluResult = {31'b0, SrcA < SrcB};
            ALU_SLL:  AluResult = SrcA << SrcB[4:0];
            ALU_SRL:  AluResult = SrcA >> SrcB[4:0];
            ALU_SRA:  AluResult = $signed(SrcA) >>> SrcB[4:0];
            default:  AluResult = 32'b0;
        endcase
    end

    assign zero = (AluResult == 32'b0);

    always_comb begin
        case (res_sel)
            RES_DATA:      Result = data_q;
            RES_ALURESULT: Result = AluResult;
            default:       Result = alu_reg;
        endcase
    end

    // Operand, data and ALU registers reload every cycle; only IR/OldPC and PC are enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC_reg    <= RESET_PC;
            oldpc_q   <= 32'b0;
            instr_reg <= 32'b0;
            a_q       <= 32'b0;
            b_q       <= 32'b0;
            data_q    <= 32'b0;
            alu_reg   <= 32'b0;
        end else begin
            if (pc_we) PC_reg <= Result;
            if (we_ir) begin
                instr_reg <= RD;
                oldpc_q   <= PC_reg;
            end
            a_q     <= rd1;
            b_q     <= rd2;
            data_q  <= RD;
            alu_reg <= AluResult;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_mc
// Brief    : Scoreboard bench for rv_mc: directed program, writeback/latency checks
// Revision : 1.0
// ============================================================================
module tb_rv_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_mc dut (.clk(clk), .rst(rst));

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;

    typedef struct {
        bit          is_mem;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  lat_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  last_fetch = -1;
    int  pcw;
    ev_t ev;
    int  lat_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] i_t(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1);
        logic [11:0] v = 12'(imm);
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input int rs1, input int rs2);
        logic [12:0] v = 13'(imm);
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [20:0] v = 21'(imm);
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] u_t(input logic [19:0] imm, input int rd);
        return {imm, 5'(rd), 7'b0110111};
    endfunction

    task automatic emit(input logic [31:0] w);
        dut.MEM.RAM[pcw] = w;
        pcw++;
    endtask
    task automatic ex(input int lat, input int rd, input logic [31:0] v);
        lat_q.push_back(lat);
        exp_q.push_back('{is_mem: 1'b0, rd: 5'(rd), addr: 32'b0, val: v});
    endtask
    task automatic ex_nowb(input int lat);
        lat_q.push_back(lat);
    endtask
    task automatic ex_mem(input int lat, input logic [31:0] a, input logic [31:0] v);
        lat_q.push_back(lat);
        exp_q.push_back('{is_mem: 1'b1, rd: 5'd0, addr: a, val: v});
    endtask

    // Monitor: every register/memory write and every instruction boundary is scored.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_fetch = -1;
        end else begin
            if (dut.CTRL.fsm.state == 4'd0) begin
                if (last_fetch >= 0 && lat_q.size() > 0) begin
                    lat_e = lat_q.pop_front();
                    check("latency", 32'(cyc - last_fetch), 32'(lat_e));
                end
                last_fetch = cyc;
            end
            if (dut.we_rf) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_regwrite: got rd=%0d val=%h expected none",
                             dut.instr_reg[11:7], dut.Result);
                end else begin
                    ev = exp_q.pop_front();
                    check("wb_kind", 32'(dut.we_rf), 32'(!ev.is_mem));
                    check("wb_rd", {27'b0, dut.instr_reg[11:7]}, {27'b0, ev.rd});
                    check("wb_val", dut.Result, ev.val);
                end
            end
            if (dut.we_mem) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_memwrite: got addr=%h expected none", dut.alu_reg);
                end else begin
                    ev = exp_q.pop_front();
                    check("mem_kind", 32'(dut.we_mem), 32'(ev.is_mem));
                    check("mem_addr", dut.alu_reg, ev.addr);
                    check("mem_data", dut.b_q, ev.val);
                end
            end
        end
    end

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && lat_q.size() == 0) break;
            @(posedge clk);
        end
        n_tests++;
        if (exp_q.size() != 0 || lat_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d/%0d pending expected 0/0", name, exp_q.size(), lat_q.size());
        end
    endtask

    initial begin
        pcw = 0;
        emit(u_t(20'h12345, 1));                 // 00 lui  x1
        emit(i_t(-5, 0, 3'b000, 4, OPI));        // 04 addi x4,x0,-5
        emit(u_t(20'h7ffff, 9));                 // 08 lui  x9
        emit(i_t(12'h7ff, 9, 3'b000, 9, OPI));   // 0c addi x9,x9,0x7ff
        emit(i_t(1024, 0, 3'b000, 10, OPI));     // 10 addi x10,x0,1024
        emit(r_t(7'h00, 10, 10, 3'b000, 11));    // 14 add  x11,x10,x10
        emit(r_t(7'h00, 11, 9, 3'b000, 12));     // 18 add  x12,x9,x11
        emit(i_t(1, 0, 3'b000, 13, OPI));        // 1c addi x13,x0,1
        emit(r_t(7'h00, 13, 12, 3'b000, 14));    // 20 add  x14,x12,x13
        emit(r_t(7'h20, 13, 14, 3'b000, 15));    // 24 sub  x15,x14,x13
        emit(i_t(10, 0, 3'b000, 16, OPI));       // 28 addi x16,x0,10
        emit(r_t(7'h00, 16, 4, 3'b010, 17));     // 2c slt  x17,x4,x16
        emit(r_t(7'h00, 16, 4, 3'b011, 18));     // 30 sltu x18,x4,x16
        emit(u_t(20'h10010, 19));                // 34 lui  x19
        emit(i_t(52, 0, 3'b000, 20, OPI));       // 38 addi x20,x0,52
        emit(s_t(0, 20, 19));                    // 3c sw   x20,0(x19)
        emit(i_t(0, 19, 3'b010, 21, OPL));       // 40 lw   x21,0(x19)
        emit(i_t(15, 0, 3'b000, 28, OPI));       // 44 addi x28,x0,15
        emit(b_t(8, 0, 0));                      // 48 beq  x0,x0,+8
        emit(i_t(99, 0, 3'b000, 28, OPI));       // 4c skipped
        emit(b_t(8, 4, 16));                     // 50 beq  x4,x16 (not taken)
        emit(i_t(3, 0, 3'b000, 5, OPI));         // 54 addi x5,x0,3
        emit(i_t(-1, 5, 3'b000, 5, OPI));        // 58 addi x5,x5,-1
        emit(b_t(8, 5, 0));                      // 5c beq  x5,x0,+8
        emit(b_t(-8, 0, 0));                     // 60 beq  x0,x0,-8
        emit(r_t(7'h00, 4, 1, 3'b100, 6));       // 64 xor
        emit(r_t(7'h00, 13, 1, 3'b110, 7));      // 68 or
        emit(r_t(7'h00, 4, 1, 3'b111, 8));       // 6c and
        emit(i_t(0, 13, 3'b001, 22, OPI));       // 70 slli 0
        emit(i_t(31, 13, 3'b001, 23, OPI));      // 74 slli 31
        emit(i_t(31, 12, 3'b101, 24, OPI));      // 78 srli 31
        emit(i_t(12'h41f, 12, 3'b101, 25, OPI)); // 7c srai 31
        emit(r_t(7'h20, 16, 14, 3'b101, 26));    // 80 sra
        emit(r_t(7'h00, 16, 14, 3'b101, 27));    // 84 srl
        emit(r_t(7'h00, 16, 13, 3'b001, 29));    // 88 sll
        emit(i_t(-1, 4, 3'b100, 31, OPI));       // 8c xori
        emit(i_t(5, 0, 3'b000, 0, OPI));         // 90 addi x0,x0,5
        emit(j_t(8, 30));                        // 94 jal  x30,+8
        emit(i_t(77, 0, 3'b000, 28, OPI));       // 98 skipped
        emit(b_t(0, 0, 0));                      // 9c halt

        ex(4, 1, 32'h12345000);  ex(4, 4, 32'hfffffffb);
        ex(4, 9, 32'h7ffff000);  ex(4, 9, 32'h7ffff7ff);
        ex(4, 10, 32'h400);      ex(4, 11, 32'h800);
        ex(4, 12, 32'h7fffffff); ex(4, 13, 32'h1);
        ex(4, 14, 32'h80000000); ex(4, 15, 32'h7fffffff);
        ex(4, 16, 32'ha);        ex(4, 17, 32'h1);  ex(4, 18, 32'h0);
        ex(4, 19, 32'h10010000); ex(4, 20, 32'h34);
        ex_mem(4, 32'h10010000, 32'h34);
        ex(5, 21, 32'h34);       ex(4, 28, 32'hf);
        ex_nowb(3); ex_nowb(3);
        ex(4, 5, 32'd3);
        ex(4, 5, 32'd2); ex_nowb(3); ex_nowb(3);
        ex(4, 5, 32'd1); ex_nowb(3); ex_nowb(3);
        ex(4, 5, 32'd0); ex_nowb(3);
        ex(4, 6, 32'hedcbaffb);  ex(4, 7, 32'h12345001); ex(4, 8, 32'h12345000);
        ex(4, 22, 32'h1);        ex(4, 23, 32'h80000000);
        ex(4, 24, 32'h0);        ex(4, 25, 32'h0);
        ex(4, 26, 32'hffe00000); ex(4, 27, 32'h00200000);
        ex(4, 29, 32'h400);      ex(4, 31, 32'h4);
        ex(4, 0, 32'h5);         ex(4, 30, 32'h98);
        ex_nowb(3);

        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", dut.PC_reg, 32'h0);
        check("reset_state", 32'(dut.CTRL.fsm.state), 32'd0);
        check("reset_x1", dut.REGFILE.registers[1], 32'h0);
        rst = 1'b0;

        drain(800, "phase1");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dut.CTRL.fsm.state == 4'd0) break;
        end
        check("halt_pc", dut.PC_reg, 32'h9c);
        check("x28_kept", dut.REGFILE.registers[28], 32'hf);
        check("x0_zero", dut.REGFILE.registers[0], 32'h0);
        check("x30_link", dut.REGFILE.registers[30], 32'h98);
        check("ram0_alias", dut.MEM.RAM[0], 32'h34);

        // Second program: lw aborted by reset in its writeback cycle, then rerun.
        @(posedge clk); #1;
        rst = 1'b1;
        dut.MEM.RAM[0]  = i_t(12'h100, 0, 3'b010, 3, OPL);
        dut.MEM.RAM[1]  = 32'h0000007f;
        dut.MEM.RAM[2]  = b_t(0, 0, 0);
        dut.MEM.RAM[64] = 32'hdeadbeef;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut.CTRL.fsm.state == 4'd3) break;
        end
        check("reach_memread", 32'(dut.CTRL.fsm.state), 32'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_pc", dut.PC_reg, 32'h0);
        check("abort_state", 32'(dut.CTRL.fsm.state), 32'd0);
        check("abort_x3", dut.REGFILE.registers[3], 32'h0);
        check("abort_ram", dut.MEM.RAM[64], 32'hdeadbeef);
        ex(5, 3, 32'hdeadbeef);
        ex_nowb(2);
        ex_nowb(3);
        rst = 1'b0;

        drain(100, "phase2");
        check("x3_loaded", dut.REGFILE.registers[3], 32'hdeadbeef);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_mc.md
Name: rv_mc

Overview:
- Multicycle RV32I subset processor: one unified instruction/data memory, one shared ALU, and an FSM controller.
- Top-level core of the multicycle design.
- Only external inputs are clock and reset; the program is preloaded into memory by the environment.
- Each instruction takes 3–5 cycles, sequenced by a controller FSM.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in unified memory; word index = addr[11:2].
- RESET_PC, 32'h00000000, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Required hierarchy/debug names (the bench probes them):
  - REGFILE.registers[0:31]: 32x32 register file.
  - MEM.RAM[0:MEM_WORDS-1]: unified memory.
  - CTRL.fsm.state: FSM state.
  - Signals: PC_reg, instr_reg, RD (memory read data), we_ir, we_rf, Result, ImmExt, SrcA, SrcB, AluResult, alu_control (4b), alu_reg.
- Reset:
  - PC_reg = RESET_PC, state = FETCH, all registers = 0.
  - Memory is not cleared.
  - Reset asserted mid-instruction aborts it; no write occurs in that cycle.
- Memory:
  - Combinational read: RD = RAM[addr[11:2]]; upper address bits ignored, so 0x10000004 aliases word 1.
  - Synchronous word write.
  - Address mux selects PC_reg in FETCH, else alu_reg.
- Registers:
  - Two combinational read ports.
  - Synchronous write when we_rf; writes to x0 discarded; x0 always reads 0.
- Datapath registers: instr_reg, OldPC (loaded with we_ir), A/B operand regs, data reg (RD), alu_reg (AluResult every cycle).
- FSM state encodings:
  - 0 FETCH: we_ir=1; instr_reg<=RD; OldPC<=PC; PC<=PC+4. Next state DECODE.
  - 1 DECODE: AluResult=OldPC+ImmB (branch target). Next state by opcode:
    - lw/sw -> MEMADR.
    - R-type -> EXECUTER.
    - I-arith -> EXECUTEI.
    - lui -> EXECUTEI.
    - beq -> BEQ.
    - jal -> JAL.
    - Unknown opcode -> FETCH (treated as NOP).
  - 2 MEMADR: rs1+ImmI/ImmS. Next state lw -> 3, sw -> 5.
  - 3 MEMREAD: read at alu_reg. Next state 4.
  - 4 MEMWB: rd<=data reg. Next state FETCH.
  - 5 MEMWRITE: RAM[alu_reg]<=rs2. Next state FETCH.
  - 6 EXECUTER: ALU on rs1, rs2. Next state 8.
  - 7 EXECUTEI: ALU on rs1 and ImmI; lui uses SrcA=0 with ImmU and add. Next state 8.
  - 8 ALUWB: rd<=alu_reg. Next state FETCH.
  - 9 BEQ: subtract rs1-rs2; if zero, PC<=alu_reg. Next state FETCH.
  - 10 JAL: PC<=OldPC+ImmJ; AluResult=OldPC+4. Next state 8 (rd<=OldPC+4).
- Cycle counts: R/I/lui/sw/jal 4, lw 5, beq 3.
- Supported instructions:
  - R-type: add, sub, and, or, xor, slt, sltu, sll, srl, sra.
  - I-type: addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
  - lw, sw, beq, jal, lui.
- ALU:
  - alu_control codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
  - 32-bit wrap-around, no overflow traps (0x7fffffff+1=0x80000000; 0x80000000-1=0x7fffffff).
  - Shift amount = SrcB[4:0].
  - sub selected only for R-type with funct7[5]=1. For funct3=101, funct7[5] selects sra/srai vs srl/srli.
  - Zero flag drives beq.
- Immediates:
  - I, S, B, J are sign-extended; U = {imm[31:12], 12'b0}.
  - B and J have bit 0 = 0.
- Result mux selects alu_reg, data reg, or AluResult.
- A self-loop (e.g. jal x0,0 or beq x0,x0,0) repeats forever with the same PC at every FETCH; this is the halt idiom.

Decomposition:
- Package rv_mc_pkg: opcode constants, FSM state encodings 0–10, alu_control codes, imm-type select, result/src mux selects.
- Natural sub-module: rv_mc_ctrl (instance CTRL), containing FSM instance fsm plus ALU/imm decoder.
- Register file and memory stay inline or as simple REGFILE/MEM instances.

Test Plan:
- lui x1,0x12345; addi x4,x0,-5 -> x1=0x12345000, x4=0xfffffffb; each completes in 4 cycles.
- addi x9 = 0x7ffff7ff path, then add to produce 0x7fffffff; add 1 -> 0x80000000; sub 1 -> 0x7fffffff; slt/sltu of -5 vs 10 -> 1 and 0 respectively.
- lui x19,0x10010; addi x20,x0,52; sw x20,0(x19); lw x21,0(x19) -> RAM[0]=0x34, x21=0x34; lw takes 5 cycles.
- beq taken skips an instruction (x28=15 preserved); not-taken falls through in 3 cycles; backward loop branch works.
- jal x30 at PC 0x94 -> x30=0x98, PC=target; addi x0,x0,5 -> x0 stays 0.
- slli by 0 and 31, srli/srai by 31 on positive values -> expected shifts; reset asserted mid-lw -> PC=0, state 0, no register write.
